gpio_sw_debounce: RTL and testbench



---
 rtl/gpio_pkg.sv | 19 +
 rtl/sw_debounce_bit.sv | 54 +++++
 rtl/gpio_sw_debounce.sv | 100 ++++++++++
 tb/tb_gpio_sw_debounce.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the switch peripheral: register offsets (addr[3:2])
// and the base of the switch window in the memory map.
package gpio_pkg;

    typedef logic [1:0] gpio_sw_sel_t;

    localparam gpio_sw_sel_t GPIO_SW_STATE_OFF = 2'd0;
    localparam gpio_sw_sel_t GPIO_SW_EDGE_OFF  = 2'd1;
    localparam gpio_sw_sel_t GPIO_SW_IRQEN_OFF = 2'd2;
    localparam gpio_sw_sel_t GPIO_SW_RISE_OFF  = 2'd3;

    localparam logic [31:0] GPIO_SW_BASE = 32'h1000_0010;

    // Counter must hold values up to DEBOUNCE_CYCLES.
    function automatic int gpio_sw_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch: 2-FF synchroniser, debounce counter and stable-level flop.
// o_accept/o_rise pulse on the edge at which a new level is accepted.
module sw_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_stable,
    output logic o_accept,
    output logic o_rise
);

    localparam int CNT_W = gpio_sw_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = (r_sync2 != r_stable);
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            // Any sample matching the stable level restarts qualification.
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_accept = w_accept;
    assign o_rise   = w_accept && r_sync2;

endmodule

// File: rtl/gpio_sw_debounce.sv
// Debounced switch peripheral with STATE / EDGE (W1C) / IRQ_EN registers and a
// level interrupt. Define GPIO_SW_RISE_ONLY_EN to add the RISE_ONLY register at 0xC.
module gpio_sw_debounce
    import gpio_pkg::*;
#(
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_in,
    input  logic [3:0]      addr,
    input  logic            en,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    logic [N_SW-1:0] w_stable;
    logic [N_SW-1:0] w_accept;
    logic [N_SW-1:0] w_rise;
    logic [N_SW-1:0] w_edge_set;
    logic [N_SW-1:0] w_edge_clr;
    logic [N_SW-1:0] w_wdata;
    gpio_sw_sel_t    w_sel;
    logic            w_wr;
    logic            w_unused_bits;

    logic [N_SW-1:0] r_edge;
    logic [N_SW-1:0] r_irq_en;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_sw     (sw_in[gi]),
            .o_stable (w_stable[gi]),
            .o_accept (w_accept[gi]),
            .o_rise   (w_rise[gi])
        );
    end

    assign w_sel      = addr[3:2];
    assign w_wr       = en && we;
    assign w_wdata    = wdata[N_SW-1:0];
    assign w_edge_clr = (w_wr && (w_sel == GPIO_SW_EDGE_OFF)) ? w_wdata : '0;

`ifdef GPIO_SW_RISE_ONLY_EN
    logic [N_SW-1:0] r_rise_only;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_only <= '0;
        end else if (w_wr && (w_sel == GPIO_SW_RISE_OFF)) begin
            r_rise_only <= w_wdata;
        end
    end

    // Falling acceptances still update STATE but are not recorded when masked.
    assign w_edge_set    = w_accept & (~r_rise_only | w_rise);
    assign w_unused_bits = ^{addr[1:0], wdata};
`else
    assign w_edge_set    = w_accept;
    assign w_unused_bits = ^{addr[1:0], wdata, w_rise};
`endif

    // Set is OR-ed in after the clear so a coincident hardware event survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge   <= '0;
            r_irq_en <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr && (w_sel == GPIO_SW_IRQEN_OFF)) begin
                r_irq_en <= w_wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (en) begin
            case (w_sel)
                GPIO_SW_STATE_OFF: rdata[N_SW-1:0] = w_stable;
                GPIO_SW_EDGE_OFF:  rdata[N_SW-1:0] = r_edge;
                GPIO_SW_IRQEN_OFF: rdata[N_SW-1:0] = r_irq_en;
`ifdef GPIO_SW_RISE_ONLY_EN
                GPIO_SW_RISE_OFF:  rdata[N_SW-1:0] = r_rise_only;
`endif
                default:           rdata = '0;
            endcase
        end
    end

    assign irq = |(r_edge & r_irq_en);

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Bench for gpio_sw_debounce with N_SW=4, DEBOUNCE_CYCLES=4: a vector table,
// hand-written corner sequences, and random traffic against a window-based model.
module tb_gpio_sw_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  sw_in;
    logic [3:0]    addr;
    logic          en;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    gpio_sw_debounce #(
        .N_SW(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw_in),
        .addr  (addr),
        .en    (en),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial forever #5 clk = ~clk;

    // Reference model: a level is accepted once the last D synchronised
    // samples all disagree with the current stable level.
    logic [N-1:0] m_raw_q[$];
    logic [N-1:0] m_s_hist[$];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_edge;
    logic [N-1:0] m_irq_en;
    logic [N-1:0] m_rise;

    task automatic model_reset();
        m_raw_q.delete();
        m_raw_q.push_back('0);
        m_raw_q.push_back('0);
        m_s_hist.delete();
        m_stable = '0;
        m_edge   = '0;
        m_irq_en = '0;
        m_rise   = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        logic [N-1:0] acc;
        logic [N-1:0] set;
        logic [N-1:0] clr;
        bit           all_diff;
        s = m_raw_q.pop_front();
        m_raw_q.push_back(sw_in);
        m_s_hist.push_back(s);
        if (m_s_hist.size() > D) void'(m_s_hist.pop_front());
        acc = '0;
        if (m_s_hist.size() == D) begin
            for (int b = 0; b < N; b++) begin
                all_diff = 1'b1;
                foreach (m_s_hist[h]) if (m_s_hist[h][b] == m_stable[b]) all_diff = 1'b0;
                acc[b] = all_diff;
            end
        end
`ifdef GPIO_SW_RISE_ONLY_EN
        set = acc & (~m_rise | s);
`else
        set = acc;
`endif
        clr = '0;
        if (en && we) begin
            case (addr[3:2])
                2'd1: clr = wdata[N-1:0];
                2'd2: m_irq_en = wdata[N-1:0];
`ifdef GPIO_SW_RISE_ONLY_EN
                2'd3: m_rise = wdata[N-1:0];
`endif
                default: ;
            endcase
        end
        m_edge   = (m_edge & ~clr) | set;
        m_stable = m_stable ^ acc;
    endtask

    function automatic logic [31:0] exp_rd(input logic e, input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        if (e) begin
            case (a[3:2])
                2'd0: v[N-1:0] = m_stable;
                2'd1: v[N-1:0] = m_edge;
                2'd2: v[N-1:0] = m_irq_en;
                default: v[N-1:0] = m_rise;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Clock/driver tasks: inputs change #1 after posedge, checks on negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
        en   = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(name, rdata, exp);
        en   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        en    = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        en    = 1'b0;
        we    = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] sw;
        logic         en;
        logic         we;
        logic [3:0]   addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] sw, input logic e, input logic w,
                                input logic [3:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ei);
        vec_t v;
        v.sw = sw; v.en = e; v.we = w; v.addr = a; v.wdata = d;
        v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        int op;

        // After release: STATE flips on the 6th edge, then register traffic.
        for (int i = 0; i < 5; i++) vecs[i] = mk(4'hF, 1, 0, 4'h0, 0, 32'h0, 0);
        vecs[5]  = mk(4'hF, 1, 0, 4'h0, 0, 32'hF, 0);
        vecs[6]  = mk(4'hF, 1, 0, 4'h4, 0, 32'hF, 0);
        vecs[7]  = mk(4'hF, 1, 1, 4'h8, 32'h5, 32'h0, 0);
        vecs[8]  = mk(4'hF, 1, 0, 4'h8, 0, 32'h5, 1);
        vecs[9]  = mk(4'hF, 1, 1, 4'h4, 32'h1, 32'hF, 1);
        vecs[10] = mk(4'hF, 1, 0, 4'h4, 0, 32'hE, 1);
        vecs[11] = mk(4'hF, 1, 1, 4'h4, 32'h4, 32'hE, 1);
        vecs[12] = mk(4'hF, 1, 0, 4'h4, 0, 32'hA, 0);
        vecs[13] = mk(4'hF, 0, 0, 4'h0, 0, 32'h0, 0);
        vecs[14] = mk(4'hF, 1, 0, 4'h3, 0, 32'hF, 0);
        vecs[15] = mk(4'hF, 1, 1, 4'h0, 32'h0, 32'hF, 0);
        vecs[16] = mk(4'hF, 1, 0, 4'h0, 0, 32'hF, 0);

        // Reset with all switches high.
        rst_n = 1'b0; sw_in = 4'hF; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) tick();
        half();
        rd_check(4'h0, 32'h0, "reset_state");
        check("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tick();
            sw_in = vecs[i].sw; en = vecs[i].en; we = vecs[i].we;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            half();
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end
        en = 1'b0; we = 1'b0;

        // Short glitch on bit 0 is discarded.
        rst_n = 1'b0; model_reset(); sw_in = 4'h0;
        repeat (2) tick();
        half();
        rst_n = 1'b1;
        repeat (3) tick();
        sw_in = 4'h1;
        repeat (3) tick();
        sw_in = 4'h0;
        repeat (8) tick();
        half();
        rd_check(4'h0, 32'h0, "glitch_state");
        rd_check(4'h4, 32'h0, "glitch_edge");
        check("glitch_irq", 32'(irq), 32'h0);

        // IRQ raise, W1C clear, STATE write ignored.
        sw_in = 4'h2;
        wr(4'h8, 32'h2);
        repeat (4) tick();
        half();
        check("irq_before_accept", 32'(irq), 32'h0);
        rd_check(4'h4, 32'h0, "edge_before_accept");
        tick();
        half();
        check("irq_on_accept", 32'(irq), 32'h1);
        rd_check(4'h4, 32'h2, "edge_on_accept");
        wr(4'h4, 32'h2);
        half();
        rd_check(4'h4, 32'h0, "edge_after_w1c");
        check("irq_after_w1c", 32'(irq), 32'h0);
        wr(4'h0, 32'h1);
        half();
        rd_check(4'h0, 32'h2, "state_write_ignored");

        // W1C landing on the acceptance edge: set wins.
        wr(4'h8, 32'h4);
        sw_in = 4'h6;
        repeat (5) tick();
        wr(4'h4, 32'h4);
        half();
        rd_check(4'h4, 32'h4, "set_beats_clear");
        check("set_beats_clear_irq", 32'(irq), 32'h1);
        rd_check(4'h0, 32'h6, "state_bit2");

        // Reset mid-debounce, then full requalification.
        sw_in = 4'hE;
        repeat (3) tick();
        half();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        rd_check(4'h0, 32'h0, "midrst_state");
        rd_check(4'h4, 32'h0, "midrst_edge");
        rd_check(4'h8, 32'h0, "midrst_irqen");
        check("midrst_irq", 32'(irq), 32'h0);
        repeat (2) tick();
        half();
        rst_n = 1'b1;
        repeat (5) tick();
        half();
        rd_check(4'h0, 32'h0, "requal_at5");
        tick();
        half();
        rd_check(4'h0, 32'hE, "requal_at6");

        // Rise-only filtering on bit 0.
        wr(4'h4, 32'hF);
        wr(4'hC, 32'h1);
        half();
`ifdef GPIO_SW_RISE_ONLY_EN
        rd_check(4'hC, 32'h1, "rise_reg");
`else
        rd_check(4'hC, 32'h0, "rise_reg");
`endif
        sw_in = 4'hF;
        repeat (6) tick();
        half();
        rd_check(4'h0, 32'hF, "rise_state");
        rd_check(4'h4, 32'h1, "rise_edge");
        wr(4'h4, 32'h1);
        sw_in = 4'hE;
        repeat (6) tick();
        half();
        rd_check(4'h0, 32'hE, "fall_state");
`ifdef GPIO_SW_RISE_ONLY_EN
        rd_check(4'h4, 32'h0, "fall_edge");
`else
        rd_check(4'h4, 32'h1, "fall_edge");
`endif

        // Random switch activity and bus traffic against the model.
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int b = 0; b < N; b++) if ($urandom_range(0, 4) == 0) sw_in[b] = ~sw_in[b];
            op    = int'($urandom_range(0, 9));
            en    = (op <= 6);
            we    = (op == 6);
            addr  = 4'($urandom_range(0, 15));
            wdata = $urandom;
            half();
            check("rnd_rdata", rdata, exp_rd(en, addr));
            check("rnd_irq", 32'(irq), 32'(|(m_edge & m_irq_en)));
        end
        en = 1'b0; we = 1'b0;
        half();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
